// File: rtl/evp_fsm_pkg.sv
// EVP polynomial evaluator: shared types and constants.
// State encodings, slot geometry and status codes used by the EVP/STP FSMs.
package evp_fsm_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int BUFFER_SIZE = 1024;
  localparam int SLOT_STRIDE = 11;
  localparam int MAX_DEGREE  = 10;

  localparam logic [31:0] STATUS_OK    = 32'd0;
  localparam logic [31:0] STATUS_OVF   = 32'd1;
  localparam logic [31:0] STATUS_BAD_N = 32'd2;
  localparam logic [31:0] STATUS_RESET = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_N  = 3'd1,
    S_CHK   = 3'd2,
    S_FETCH = 3'd3,
    S_MAC   = 3'd4,
    S_ERROR = 3'd5,
    S_END   = 3'd6
  } evp_state_e;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/evp_fsm_mac.sv
// Combinational Horner step: sum = acc*x + coeff, with 32-bit range flag.
// The wrapped sum is returned; ovf_o flags that the exact sum left int32.
module horner_mac
  import evp_fsm_pkg::*;
#(
  parameter int W = WORD_SIZE
) (
  input  logic signed [31:0]  acc_i,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] coeff_i,
  output logic        [31:0]  sum_o,
  output logic                ovf_o
);

  localparam int PW = 32 + W;
  localparam int FW = PW + 1;

  logic signed [PW-1:0] prod;
  logic signed [FW-1:0] full;

  always_comb begin
    prod  = PW'(acc_i) * PW'(x_i);
    full  = FW'(prod) + FW'(coeff_i);
    sum_o = full[31:0];
    ovf_o = (full != FW'(signed'(full[31:0])));
  end

endmodule

// File: rtl/evp_fsm.sv
// EVP FSM: reads degree and coefficients of slot A, evaluates p(x) by Horner.
// Shares S/N RAM read ports with the STP FSM; result/status are registered.
module evp_fsm
  import evp_fsm_pkg::*;
#(
  parameter int word_size   = WORD_SIZE,
  parameter int buffer_size = BUFFER_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_evp,
  input  logic [2:0]                   A,
  input  logic [word_size-1:0]         x,
  input  logic [4:0]                   rd_data_N,
  input  logic [word_size-1:0]         rd_data_S,
  output logic                         en_rd_N,
  output logic [2:0]                   rd_addr_N,
  output logic                         en_rd_S,
  output logic [log2(buffer_size)-1:0] rd_addr_S,
  output logic                         done_evp,
  output logic [31:0]                  result,
  output logic [31:0]                  status
);

  localparam int AW = log2(buffer_size);

  evp_state_e           state_q, state_d;
  logic [2:0]           a_q, a_d;
  logic [word_size-1:0] x_q, x_d;
  logic [3:0]           idx_q, idx_d;
  logic [31:0]          acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic [31:0]          res_q, res_d;
  logic [31:0]          sts_q, sts_d;

  logic [31:0] mac_sum;
  logic        mac_ovf;

  horner_mac #(.W(word_size)) u_mac (
    .acc_i   (acc_q),
    .x_i     (x_q),
    .coeff_i (rd_data_S),
    .sum_o   (mac_sum),
    .ovf_o   (mac_ovf)
  );

  assign en_rd_N   = (state_q == S_RD_N);
  assign en_rd_S   = (state_q == S_FETCH);
  assign done_evp  = (state_q == S_END);
  assign rd_addr_N = a_q;
  assign rd_addr_S = AW'(a_q) * AW'(SLOT_STRIDE) + AW'(idx_q);
  assign result    = res_q;
  assign status    = sts_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    res_d   = res_q;
    sts_d   = sts_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_evp) begin
          a_d     = A;
          x_d     = x;
          state_d = S_RD_N;
        end
      end
      S_RD_N: state_d = S_CHK;
      S_CHK: begin
        if (rd_data_N > 5'(MAX_DEGREE)) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          err_d   = 1'b0;
          idx_d   = rd_data_N[3:0];
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_MAC;
      S_MAC: begin
        acc_d = mac_sum;
        ovf_d = ovf_q | mac_ovf;
        if (idx_q == 4'd0) begin
          state_d = S_END;
        end else begin
          idx_d   = idx_q - 4'd1;
          state_d = S_FETCH;
        end
      end
      S_ERROR: begin
        res_d   = '0;
        sts_d   = STATUS_BAD_N;
        state_d = S_END;
      end
      S_END: begin
        if (!err_q) begin
          res_d = acc_q;
          sts_d = ovf_q ? STATUS_OVF : STATUS_OK;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      x_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      sts_q   <= STATUS_RESET;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      res_q   <= res_d;
      sts_q   <= sts_d;
    end
  end

endmodule

// File: tb/tb_evp_fsm.sv
// Self-checking bench for evp_fsm with RAM models and a scoreboard.
module tb_evp_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_evp;
  logic [2:0]  A;
  logic [15:0] x;
  logic [4:0]  rd_data_N;
  logic [15:0] rd_data_S;
  logic        en_rd_N, en_rd_S, done_evp;
  logic [2:0]  rd_addr_N;
  logic [9:0]  rd_addr_S;
  logic [31:0] result, status;

  evp_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .start_evp (start_evp),
    .A         (A),
    .x         (x),
    .rd_data_N (rd_data_N),
    .rd_data_S (rd_data_S),
    .en_rd_N   (en_rd_N),
    .rd_addr_N (rd_addr_N),
    .en_rd_S   (en_rd_S),
    .rd_addr_S (rd_addr_S),
    .done_evp  (done_evp),
    .result    (result),
    .status    (status)
  );

  always #5 clk = ~clk;

  logic [4:0]  nram [8];
  logic [15:0] sram [1024];

  always @(posedge clk) begin
    if (en_rd_N) rd_data_N <= nram[rd_addr_N];
    if (en_rd_S) rd_data_S <= sram[rd_addr_S];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    int          cyc;
  } exp_t;

  exp_t        expq [$];
  int          addrq [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ndone = 0;
  bit          pend = 0;
  logic [31:0] pr, ps;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic void push_exp(input int a, input logic [15:0] xv,
                                   input int k);
    int     n;
    longint acc, full;
    bit     ovf;
    exp_t   e;
    n   = int'(nram[a]);
    acc = 0;
    ovf = 0;
    if (n > 10) begin
      e = '{32'd0, 32'd2, k + 4};
    end else begin
      for (int i = n; i >= 0; i--) begin
        addrq.push_back(a * 11 + i);
        full = acc * longint'($signed(xv))
             + longint'($signed(sram[a * 11 + i]));
        if (full > 64'sd2147483647 || full < -64'sd2147483648) ovf = 1;
        acc = longint'($signed(full[31:0]));
      end
      e = '{acc[31:0], {31'd0, ovf}, k + 2 * n + 5};
    end
    expq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (pend) begin
        check("result", result, pr);
        check("status", status, ps);
        pend = 0;
      end
      if (done_evp) begin
        ndone++;
        if (expq.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("done_cycle", cyc, e.cyc);
          pr   = e.res;
          ps   = e.st;
          pend = 1;
        end
      end
      if (en_rd_S) begin
        if (addrq.size() == 0)
          check("unexpected_s_read", 32'(rd_addr_S), 32'hFFFF_FFFF);
        else
          check("s_addr", 32'(rd_addr_S), 32'(addrq.pop_front()));
      end
    end
  end

  task automatic start_op(input logic [2:0] a, input logic [15:0] xv);
    A         = a;
    x         = xv;
    start_evp = 1'b1;
    push_exp(a, xv, cyc);
    @(negedge clk);
    start_evp = 1'b0;
    A         = 3'($urandom);
    x         = 16'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((expq.size() != 0 || pend) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_done", 32'(done_evp), 32'd0);
    check("rst_en_n", 32'(en_rd_N), 32'd0);
    check("rst_en_s", 32'(en_rd_S), 32'd0);
    check("rst_addr_n", 32'(rd_addr_N), 32'd0);
    check("rst_addr_s", 32'(rd_addr_S), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_status", status, 32'hFFFF_FFFF);
  endtask

  initial begin
    int k, d0;
    rst       = 1'b0;
    start_evp = 1'b0;
    A         = '0;
    x         = '0;
    for (int i = 0; i < 8; i++) nram[i] = '0;
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    nram[2] = 5'd2;
    sram[22] = 16'd3;
    sram[23] = 16'd2;
    sram[24] = 16'd1;
    nram[0] = 5'd0;
    sram[0] = 16'hFFF9;
    nram[4] = 5'd12;
    nram[1] = 5'd10;
    for (int i = 11; i <= 21; i++) sram[i] = 16'h7FFF;

    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    @(negedge clk);

    start_op(3'd2, 16'd5);
    wait_done();
    check("s1_result", result, 32'd38);

    start_op(3'd0, 16'd100);
    wait_done();
    check("s2_result", result, 32'hFFFF_FFF9);

    start_op(3'd4, 16'd7);
    wait_done();
    check("s3_status", status, 32'd2);

    start_op(3'd1, 16'h7FFF);
    wait_done();
    check("s4_status", status, 32'd1);

    d0 = ndone;
    start_op(3'd2, 16'd5);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals();
    expq.delete();
    addrq.delete();
    pend = 0;
    @(negedge clk);
    check("abort_no_done", 32'(ndone - d0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    start_op(3'd2, 16'd5);
    wait_done();
    check("s5_result", result, 32'd38);

    d0        = ndone;
    A         = 3'd2;
    x         = 16'd5;
    start_evp = 1'b1;
    k         = cyc;
    push_exp(2, 16'd5, k);
    push_exp(2, 16'd5, k + 10);
    repeat (11) @(negedge clk);
    start_evp = 1'b0;
    wait_done();
    check("s6_done_count", 32'(ndone - d0), 32'd2);
    check("s6_result", result, 32'd38);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/evp_fsm.md
# evp_fsm

Executes the EVP (evaluate polynomial) instruction, the read-side counterpart of STP. It reads the degree of coefficient slot A from N RAM and the coefficients c0..cN stored by STP at S RAM addresses A*11+i. It evaluates p(x) by Horner's method and presents a 32-bit result and status word to the result/status FIFOs. It sits beside the STP FSM under the instruction controller and shares the S RAM and N RAM read ports.

## Interface
- word_size, 16, coefficient and x width (signed two's complement)
- buffer_size, 1024, S RAM depth; S address width is log2(buffer_size)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start_evp  input  1  one-cycle start pulse from controller, sampled only in IDLE
- A  input  3  coefficient slot index, captured at start
- x  input  word_size  evaluation point, captured at start
- rd_data_N  input  5  N RAM read data, valid the cycle after en_rd_N
- rd_data_S  input  word_size  S RAM read data, valid the cycle after en_rd_S
- en_rd_N  output  1  N RAM read enable
- rd_addr_N  output  3  N RAM address (= captured A)
- en_rd_S  output  1  S RAM read enable
- rd_addr_S  output  log2(buffer_size)  S RAM address
- done_evp  output  1  one-cycle completion pulse
- result  output  32  evaluated value, signed
- status  output  32  0 = ok, 1 = overflow, 2 = invalid degree

## Operation
- Reset values: done_evp=0, en_rd_N=0, en_rd_S=0, rd_addr_N=0, rd_addr_S=0, result=0, status=32'hFFFFFFFF, state=IDLE.
- IDLE: start_evp=1 latches A, x; go RD_N. Otherwise stay IDLE.
- RD_N: en_rd_N=1, rd_addr_N=A; go CHK.
- CHK: latch N=rd_data_N. If N>10, go ERROR. Else set idx=N, acc=0, ovf=0, and go FETCH.
- FETCH: en_rd_S=1, rd_addr_S=A*11+idx; go MAC.
- MAC: acc <= trunc32(acc*x + sext(rd_data_S)). If idx==0, go END; else idx-1 and go FETCH.
- ERROR: result<=0, status<=2; go END. No S RAM reads are issued.
- END: done_evp=1. On a success path, result<=acc and status<=ovf?1:0. Go IDLE.
- Arithmetic is signed. The product is acc(32) x x(16) computed at 48 bits, and the coefficient is sign-extended before the add. The sum is truncated to 32 bits.
- ovf becomes 1 and stays set (sticky) if any intermediate sum falls outside [-2^31, 2^31-1]. The result is still the wrapped value.
- Coefficients are read highest first: addresses A*11+N down to A*11.
- en_rd_* are deasserted in every state not listed above.
- result and status hold their values until the next END or reset.
- start_evp outside IDLE is ignored, and so is a start in the END cycle. A start in the first IDLE cycle after END is accepted.
- A, x and N are held internally, so changes on the inputs during an operation have no effect.
- Reset mid-operation returns every register to its reset value immediately. No done_evp is emitted for the aborted operation.

## Timing
- Cycle k = the cycle in which start_evp is sampled high in IDLE.
- Success: done_evp is high in cycle k+2N+5; 2 cycles per coefficient. For N=0, done is at k+5.
- Error: done_evp is high in cycle k+4.
- RAM model: synchronous read. Data appears in the cycle after the enable/address cycle.
- result and status are valid from the cycle after done_evp (registered at END).
- Back-to-back throughput: next start is accepted at k+2N+6 at the earliest.

## Structure
- Shared package holds:
  - state encodings (7 states, 3 bits)
  - SLOT_STRIDE=11, MAX_DEGREE=10
  - STATUS_OK=0, STATUS_OVF=1, STATUS_BAD_N=2, STATUS_RESET=32'hFFFFFFFF
  - the log2 function, shared with the STP FSM
- One sub-module, horner_mac. It is a combinational 32x16 signed multiply-add taking acc, x and coeff, and returns sum[31:0] and an overflow flag. The FSM registers its outputs.

## Test plan
- A=2, N RAM[2]=2, S[22..24]={3,2,1}, x=5 -> S read order 24,23,22; result=38, status=0; done at k+9.
- A=0, N=0, S[0]=16'hFFF9, x=100 -> result=32'hFFFFFFF9, status=0; done at k+5.
- A=4, N RAM[4]=12 -> en_rd_S never asserted; result=0, status=2; done at k+4.
- A=1, N=10, all coeffs 16'h7FFF, x=16'h7FFF -> status=1, result equals the 32-bit-wrapped reference model value; done at k+25.
- Assert rst low during the third MAC of scenario 1 -> outputs return to reset values with no done_evp. A fresh start then reproduces result=38.
- Pulse start_evp every cycle during scenario 1 -> exactly one done. A start in the IDLE cycle right after END begins a second evaluation.
